// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin over WIDTH bits, BPC bits per clock, LSB chunk first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int S  = WIDTH / BPC;
  localparam int CW = ($clog2(S + 1) < 1) ? 1 : $clog2(S + 1);

  if ((WIDTH < 1) || (BPC < 1) || ((WIDTH % BPC) != 0)) begin : g_param_check
    $error("serial_subtractor: BPC must be >= 1 and divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic            borrow;
  logic [CW-1:0]   cnt;
  logic            last_step;
  logic [BPC-1:0]  a_ch, b_ch;
  logic [BPC:0]    chunk;

  assign last_step = (cnt == CW'(S - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select the current chunk with constant part-selects, one comparator per chunk index.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int i = 0; i < S; i++) begin
      if (cnt == CW'(i)) begin
        a_ch = a_r[i*BPC +: BPC];
        b_ch = b_r[i*BPC +: BPC];
      end
    end
  end

  // The extra MSB of the widened difference is the chunk's borrow out.
  assign chunk = {1'b0, a_ch} - {1'b0, b_ch} - {{BPC{1'b0}}, borrow};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < S; i++) begin
            if (cnt == CW'(i)) diff[i*BPC +: BPC] <= chunk[BPC-1:0];
          end
          borrow <= chunk[BPC];
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            bout <= chunk[BPC];
`ifdef SERIAL_SUB_OVF_EN
            // On the last step chunk[BPC-1] is the final sign bit of diff.
            ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (chunk[BPC-1] != a_r[WIDTH-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: three instances (W8/B1, W8/B4, W4/B1),
// a directed vector table, a mid-run reset sequence and randomized / exhaustive ops.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] iv, ordy, ir, ov, bz, bo, ovf_v;
  logic [7:0] a_bus, b_bus;
  logic       bin_bus;
  logic [7:0] d0, d1;
  logic [3:0] d2;
  logic [7:0] dv [3];

  int n_vec = 0;
  int n_err = 0;
  int wid [3] = '{8, 8, 4};
  int stp [3] = '{8, 2, 4};

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .BPC(1)) u_w8b1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_bus), .b(b_bus),
    .bin(bin_bus), .out_valid(ov[0]), .out_ready(ordy[0]), .diff(d0), .bout(bo[0]), .busy(bz[0])
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf_v[0])
`endif
  );

  serial_subtractor #(.WIDTH(8), .BPC(4)) u_w8b4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_bus), .b(b_bus),
    .bin(bin_bus), .out_valid(ov[1]), .out_ready(ordy[1]), .diff(d1), .bout(bo[1]), .busy(bz[1])
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf_v[1])
`endif
  );

  serial_subtractor #(.WIDTH(4), .BPC(1)) u_w4b1 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_bus[3:0]), .b(b_bus[3:0]),
    .bin(bin_bus), .out_valid(ov[2]), .out_ready(ordy[2]), .diff(d2), .bout(bo[2]), .busy(bz[2])
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf_v[2])
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf_v = '0;
`endif

  always_comb begin
    dv[0] = d0;
    dv[1] = d1;
    dv[2] = {4'h0, d2};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned operands, then the signed-overflow rule.
  function automatic void model(input int w, input int a, input int b, input int bin,
                                output logic [7:0] d, output logic bw, output logic ovf);
    int r;
    int m;
    m   = (1 << w) - 1;
    r   = (a & m) - (b & m) - bin;
    d   = 8'(r & m);
    bw  = (r < 0);
    ovf = ((((a >> (w - 1)) & 1) != ((b >> (w - 1)) & 1)) &&
           (((r >> (w - 1)) & 1) != ((a >> (w - 1)) & 1)));
  endfunction

  // One complete transaction on instance sel; called and returning on a negedge.
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input int pre_gap, input int hold);
    int lat;
    repeat (pre_gap) @(negedge clk);
    check($sformatf("in_ready_idle[%0d]", sel), 32'(ir[sel]), 32'd1);
    a_bus   = a;
    b_bus   = b;
    bin_bus = bin;
    iv[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[sel] = 1'b0;
    // Operands are sampled only at the accept edge; scramble them now.
    a_bus   = 8'($urandom);
    b_bus   = 8'($urandom);
    bin_bus = 1'($urandom);
    check($sformatf("busy_run[%0d]", sel), 32'(bz[sel]), 32'd1);
    lat = 0;
    while (!ov[sel] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency[%0d]", sel), 32'(lat), 32'(stp[sel]));
    check($sformatf("diff[%0d] a=%0h b=%0h bin=%0b", sel, a, b, bin), 32'(dv[sel]), 32'(ed));
    check($sformatf("bout[%0d] a=%0h b=%0h bin=%0b", sel, a, b, bin), 32'(bo[sel]), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check($sformatf("ovf[%0d] a=%0h b=%0h bin=%0b", sel, a, b, bin), 32'(ovf_v[sel]), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unknown ovf expectation");
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check($sformatf("hold_valid[%0d]", sel), 32'(ov[sel]), 32'd1);
      check($sformatf("hold_diff[%0d]", sel), 32'(dv[sel]), 32'(ed));
      check($sformatf("hold_bout[%0d]", sel), 32'(bo[sel]), 32'(eb));
      check($sformatf("hold_in_ready[%0d]", sel), 32'(ir[sel]), 32'd0);
    end
    ordy[sel] = 1'b1;
    @(negedge clk);
    ordy[sel] = 1'b0;
    check($sformatf("post_hs_valid[%0d]", sel), 32'(ov[sel]), 32'd0);
    check($sformatf("post_hs_in_ready[%0d]", sel), 32'(ir[sel]), 32'd1);
  endtask

  task automatic rand_op(input int sel, input int a, input int b, input int bin,
                         input int pre_gap, input int hold);
    logic [7:0] ed;
    logic       eb, eo;
    model(wid[sel], a, b, bin, ed, eb, eo);
    run_op(sel, 8'(a), 8'(b), 1'(bin), ed, eb, eo, pre_gap, hold);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    int         hold;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int lat;
    tbl[0] = '{sel: 0, a: 8'h05, b: 8'h03, bin: 1'b0, diff: 8'h02, bout: 1'b0, ovf: 1'b0, hold: 0};
    tbl[1] = '{sel: 0, a: 8'h00, b: 8'h01, bin: 1'b1, diff: 8'hFE, bout: 1'b1, ovf: 1'b0, hold: 0};
    tbl[2] = '{sel: 0, a: 8'hA5, b: 8'h5A, bin: 1'b0, diff: 8'h4B, bout: 1'b0, ovf: 1'b1, hold: 5};
    tbl[3] = '{sel: 1, a: 8'h80, b: 8'h01, bin: 1'b0, diff: 8'h7F, bout: 1'b0, ovf: 1'b1, hold: 0};
    tbl[4] = '{sel: 1, a: 8'hFF, b: 8'hFF, bin: 1'b1, diff: 8'hFF, bout: 1'b1, ovf: 1'b0, hold: 2};
    tbl[5] = '{sel: 1, a: 8'hFF, b: 8'h00, bin: 1'b0, diff: 8'hFF, bout: 1'b0, ovf: 1'b0, hold: 0};
    tbl[6] = '{sel: 2, a: 8'h03, b: 8'h05, bin: 1'b1, diff: 8'h0D, bout: 1'b1, ovf: 1'b0, hold: 1};

    rst = 1'b1; iv = '0; ordy = '0; a_bus = '0; b_bus = '0; bin_bus = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_in_ready[%0d]", s), 32'(ir[s]), 32'd1);
      check($sformatf("rst_out_valid[%0d]", s), 32'(ov[s]), 32'd0);
      check($sformatf("rst_busy[%0d]", s), 32'(bz[s]), 32'd0);
      check($sformatf("rst_diff[%0d]", s), 32'(dv[s]), 32'd0);
      check($sformatf("rst_bout[%0d]", s), 32'(bo[s]), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check($sformatf("rst_ovf[%0d]", s), 32'(ovf_v[s]), 32'd0);
`endif
    end

    for (int i = 0; i < 7; i++)
      run_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].diff, tbl[i].bout,
             tbl[i].ovf, 0, tbl[i].hold);

    // Reset in the middle of RUN: no result may appear, reset values must apply.
    a_bus = 8'h33; b_bus = 8'h11; bin_bus = 1'b0; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_rst", 32'(bz[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 32'(ir[0]), 32'd1);
    check("midrst_busy", 32'(bz[0]), 32'd0);
    check("midrst_diff", 32'(dv[0]), 32'd0);
    check("midrst_bout", 32'(bo[0]), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_valid", 32'(ov[0]), 32'd0);
    end
    run_op(0, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0, 0);

    // Back-to-back ops with out_ready held high give the minimum initiation interval.
    ordy[0] = 1'b1;
    a_bus = 8'h40; b_bus = 8'h20; bin_bus = 1'b1; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    lat = 1;
    while (!ir[0] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    ordy[0] = 1'b0;
    check("min_ii", 32'(lat), 32'd10);
    check("min_ii_diff", 32'(dv[0]), 32'h1F);

    for (int i = 0; i < 120; i++)
      rand_op(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    for (int i = 0; i < 120; i++)
      rand_op(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          rand_op(2, a, b, c, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
